// File: rtl/conv_1x1_mac_engine.sv
//==============================================================================
// Module   : conv_1x1_mac_engine
// Purpose  : Fixed-point 1x1 (pointwise) convolution engine. Holds the full
//            CO x CI weight set on chip, collects one pixel's CI channel words,
//            then runs a single-MAC pipeline producing one requantised
//            (shift, optional ReLU, saturate) result per output channel.
//            Optional stride-2 decimation drops odd rows/columns.
// Ports    : clk             - rising-edge clock
//            reset           - asynchronous active-low reset
//            valid_weight_in - weight word strobe (co-major order)
//            weight_in       - weight word
//            weight_clear    - 1-cycle pulse, drops weights and any pixel
//            valid_in        - pixel channel word strobe
//            pxl_in          - pixel channel word (ci order, raster pixels)
//            ready_in        - engine accepts a pixel word this cycle
//            pxl_out         - result word (co order)
//            valid_out       - pxl_out valid, single-cycle
//            weights_loaded  - full weight set present
//            frame_done      - with last result of the frame's last pixel
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_1x1_mac_engine #(
   parameter int DATA_WIDTH      = 16,
   parameter int FRAC_BITS       = 8,
   parameter int IMAGE_WIDTH     = 16,
   parameter int IMAGE_HEIGHT    = 16,
   parameter int CHANNEL_NUM_IN  = 256,
   parameter int CHANNEL_NUM_OUT = 512,
   parameter int STRIDE2         = 0,
   parameter int RELU_EN         = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_weight_in,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  weight_clear,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic                  ready_in,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   output logic                  weights_loaded,
   output logic                  frame_done
);

   localparam int DEPTH = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
   localparam int WA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CA    = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
   localparam int XA    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
   localparam int YA    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int AW    = PW + $clog2(CHANNEL_NUM_IN);

   localparam logic [WA-1:0] W_LAST   = WA'(DEPTH - 1);
   localparam logic [CA-1:0] CI_LAST  = CA'(CHANNEL_NUM_IN - 1);
   localparam logic [XA-1:0] COL_LAST = XA'(IMAGE_WIDTH - 1);
   localparam logic [YA-1:0] ROW_LAST = YA'(IMAGE_HEIGHT - 1);
   // Position of the last pixel that is actually computed in a frame; with
   // decimation that is the last even row/column, so frame_done still fires
   // even when the frame's final raster pixel is dropped.
   localparam logic [XA-1:0] COL_FINAL =
      XA'((STRIDE2 != 0) ? ((IMAGE_WIDTH - 1) / 2) * 2 : IMAGE_WIDTH - 1);
   localparam logic [YA-1:0] ROW_FINAL =
      YA'((STRIDE2 != 0) ? ((IMAGE_HEIGHT - 1) / 2) * 2 : IMAGE_HEIGHT - 1);

   localparam logic signed [AW-1:0] SAT_MAX = AW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, LOAD_W, COLLECT, COMPUTE} state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] wram [DEPTH];
   logic [DATA_WIDTH-1:0] vec  [CHANNEL_NUM_IN];

   logic [WA-1:0] w_cnt;
   logic [CA-1:0] ci_cnt;
   logic [XA-1:0] col;
   logic [YA-1:0] row;
   logic          pix_frame_last;

   logic          iss_busy;
   logic [WA-1:0] iss_addr;
   logic [CA-1:0] iss_ci;

   logic                         s1_valid, s1_first, s1_last_ci, s1_last_all;
   logic signed [DATA_WIDTH-1:0] s1_w, s1_x;
   logic                         s2_valid, s2_first, s2_last_ci, s2_last_all;
   logic signed [PW-1:0]         s2_prod;
   logic signed [AW-1:0]         acc;
   logic                         out_last;

   logic                         wt_wr, pix_acc, pix_end, keep;
   logic signed [AW-1:0]         prod_ext, sum_nxt, shifted, clipped;
   logic [DATA_WIDTH-1:0]        quant;

   // Word-level handshakes; a clear in the same cycle swallows the word.
   assign wt_wr   = valid_weight_in && !weight_clear &&
                    (state == IDLE || state == LOAD_W);
   assign pix_acc = valid_in && (state == COLLECT) && !weight_clear;
   assign pix_end = pix_acc && (ci_cnt == CI_LAST);
   assign keep    = (STRIDE2 == 0) || (!row[0] && !col[0]);

   //---------------------------------------------------------------------------
   // FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      ready_in       = 1'b0;
      weights_loaded = 1'b0;
      case (state)
         IDLE: begin
            if (wt_wr) state_nxt = (w_cnt == W_LAST) ? COLLECT : LOAD_W;
         end
         LOAD_W: begin
            if (wt_wr && (w_cnt == W_LAST)) state_nxt = COLLECT;
         end
         COLLECT: begin
            ready_in       = 1'b1;
            weights_loaded = 1'b1;
            if (pix_end && keep) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            weights_loaded = 1'b1;
            // Leave once the pixel's final result is on the output.
            if (valid_out && out_last) state_nxt = COLLECT;
         end
         default: state_nxt = IDLE;
      endcase
      if (weight_clear) state_nxt = IDLE;
   end

   //---------------------------------------------------------------------------
   // Counters: weight load, channel collect, pixel position, MAC issue
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_cnt          <= '0;
         ci_cnt         <= '0;
         col            <= '0;
         row            <= '0;
         pix_frame_last <= 1'b0;
         iss_busy       <= 1'b0;
         iss_addr       <= '0;
         iss_ci         <= '0;
      end else if (weight_clear) begin
         w_cnt          <= '0;
         ci_cnt         <= '0;
         col            <= '0;
         row            <= '0;
         pix_frame_last <= 1'b0;
         iss_busy       <= 1'b0;
         iss_addr       <= '0;
         iss_ci         <= '0;
      end else begin
         if (wt_wr) w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;

         if (pix_acc) begin
            if (ci_cnt == CI_LAST) begin
               ci_cnt <= '0;
               if (keep) pix_frame_last <= (row == ROW_FINAL) && (col == COL_FINAL);
               if (col == COL_LAST) begin
                  col <= '0;
                  row <= (row == ROW_LAST) ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end else begin
               ci_cnt <= ci_cnt + 1'b1;
            end
         end

         // The co-major weight address advances linearly; iss_ci tracks the
         // matching vector index and wraps every CI issues.
         if (iss_busy) begin
            if (iss_addr == W_LAST) begin
               iss_busy <= 1'b0;
               iss_addr <= '0;
               iss_ci   <= '0;
            end else begin
               iss_addr <= iss_addr + 1'b1;
               iss_ci   <= (iss_ci == CI_LAST) ? '0 : iss_ci + 1'b1;
            end
         end else if (pix_end && keep) begin
            iss_busy <= 1'b1;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Storage and stage-1 read (no reset so the arrays map onto block RAM)
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wt_wr)   wram[w_cnt]  <= weight_in;
      if (pix_acc) vec[ci_cnt]  <= pxl_in;
      s1_w <= wram[iss_addr];
      s1_x <= vec[iss_ci];
   end

   //---------------------------------------------------------------------------
   // Accumulate and requantise
   //---------------------------------------------------------------------------
   always_comb begin
      prod_ext = AW'(s2_prod);
      sum_nxt  = s2_first ? prod_ext : acc + prod_ext;
      shifted  = sum_nxt >>> FRAC_BITS;
      clipped  = shifted;
      if ((RELU_EN != 0) && shifted[AW-1]) clipped = '0;
      quant = clipped[DATA_WIDTH-1:0];
      if (clipped > SAT_MAX)      quant = SAT_MAX[DATA_WIDTH-1:0];
      else if (clipped < SAT_MIN) quant = SAT_MIN[DATA_WIDTH-1:0];
   end

   //---------------------------------------------------------------------------
   // Pipeline stages 1-3 control and output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid    <= 1'b0;
         s1_first    <= 1'b0;
         s1_last_ci  <= 1'b0;
         s1_last_all <= 1'b0;
         s2_valid    <= 1'b0;
         s2_first    <= 1'b0;
         s2_last_ci  <= 1'b0;
         s2_last_all <= 1'b0;
         s2_prod     <= '0;
         acc         <= '0;
         out_last    <= 1'b0;
         pxl_out     <= '0;
         valid_out   <= 1'b0;
         frame_done  <= 1'b0;
      end else if (weight_clear) begin
         // Flush in-flight MACs so the aborted pixel never reaches the output.
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         out_last   <= 1'b0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         s1_valid    <= iss_busy;
         s1_first    <= (iss_ci == '0);
         s1_last_ci  <= (iss_ci == CI_LAST);
         s1_last_all <= (iss_addr == W_LAST);

         s2_valid    <= s1_valid;
         s2_first    <= s1_first;
         s2_last_ci  <= s1_last_ci;
         s2_last_all <= s1_last_all;
         s2_prod     <= s1_w * s1_x;

         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (s2_valid) begin
            acc <= sum_nxt;
            if (s2_last_ci) begin
               valid_out  <= 1'b1;
               pxl_out    <= quant;
               out_last   <= s2_last_all;
               frame_done <= s2_last_all && pix_frame_last;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_1x1_mac_engine.sv
//==============================================================================
// Module   : tb_conv_1x1_mac_engine
// Purpose  : Directed self-checking bench for conv_1x1_mac_engine with
//            CI=4, CO=2, 4x4 image. Instance dut uses stride-2 without ReLU;
//            instance dut_r shares all inputs and enables ReLU without stride.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_1x1_mac_engine;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          valid_weight_in = 1'b0;
   logic [DW-1:0] weight_in = '0;
   logic          weight_clear = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] pxl_in = '0;

   logic          ready_in, valid_out, weights_loaded, frame_done;
   logic [DW-1:0] pxl_out;
   logic          ready_in_r, valid_out_r, weights_loaded_r, frame_done_r;
   logic [DW-1:0] pxl_out_r;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int fd_pulses = 0;

   logic [DW-1:0] q_val[$];
   logic [DW-1:0] q_val_r[$];
   int            q_cyc[$];
   bit            q_fd[$];

   conv_1x1_mac_engine #(
      .DATA_WIDTH(16), .FRAC_BITS(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
      .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2), .STRIDE2(1), .RELU_EN(0)
   ) dut (
      .clk(clk), .reset(reset), .valid_weight_in(valid_weight_in),
      .weight_in(weight_in), .weight_clear(weight_clear), .valid_in(valid_in),
      .pxl_in(pxl_in), .ready_in(ready_in), .pxl_out(pxl_out),
      .valid_out(valid_out), .weights_loaded(weights_loaded),
      .frame_done(frame_done)
   );

   conv_1x1_mac_engine #(
      .DATA_WIDTH(16), .FRAC_BITS(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
      .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2), .STRIDE2(0), .RELU_EN(1)
   ) dut_r (
      .clk(clk), .reset(reset), .valid_weight_in(valid_weight_in),
      .weight_in(weight_in), .weight_clear(weight_clear), .valid_in(valid_in),
      .pxl_in(pxl_in), .ready_in(ready_in_r), .pxl_out(pxl_out_r),
      .valid_out(valid_out_r), .weights_loaded(weights_loaded_r),
      .frame_done(frame_done_r)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output recorder, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         if (valid_out) begin
            q_val.push_back(pxl_out);
            q_cyc.push_back(cyc);
            q_fd.push_back(frame_done);
         end
         if (frame_done) fd_pulses++;
         if (valid_out_r) q_val_r.push_back(pxl_out_r);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic clear_q();
      q_val.delete();
      q_val_r.delete();
      q_cyc.delete();
      q_fd.delete();
      fd_pulses = 0;
   endtask

   task automatic pulse_clear();
      weight_clear = 1'b1;
      tick();
      weight_clear = 1'b0;
   endtask

   task automatic load_w(input logic [DW-1:0] a, input logic [DW-1:0] b);
      for (int i = 0; i < 8; i++) begin
         valid_weight_in = 1'b1;
         weight_in       = (i < 4) ? a : b;
         tick();
      end
      valid_weight_in = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] v, output int t, output bit ok);
      int n;
      n        = 0;
      valid_in = 1'b1;
      pxl_in   = v;
      while (ready_in !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      ok = (n < 200);
      t  = cyc;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic send_pixel(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                             input logic [DW-1:0] c2, input logic [DW-1:0] c3,
                             output int t, output bit ok);
      bit o0, o1, o2, o3;
      send_word(c0, t, o0);
      send_word(c1, t, o1);
      send_word(c2, t, o2);
      send_word(c3, t, o3);
      ok = o0 && o1 && o2 && o3;
   endtask

   task automatic wait_q(input int n, input int limit);
      int k;
      k = 0;
      while (q_val.size() < n && k < limit) begin
         tick();
         k++;
      end
   endtask

   //---------------------------------------------------------------------------
   task automatic test_reset();
      repeat (2) tick();
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready_in); end
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      vectors++; if (weights_loaded !== 1'b0) begin miscompares++; $display("FAIL reset_loaded: got %b want 0", weights_loaded); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      vectors++; if (pxl_out !== 16'h0000) begin miscompares++; $display("FAIL reset_pxl: got %h want 0000", pxl_out); end
      reset = 1'b1;
      tick();
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL post_reset_ready: got %b want 0", ready_in); end
   endtask

   task automatic test_weight_load();
      for (int i = 0; i < 7; i++) begin
         valid_weight_in = 1'b1;
         weight_in       = 16'h0100;
         tick();
      end
      vectors++; if (weights_loaded !== 1'b0) begin miscompares++; $display("FAIL load7_loaded: got %b want 0", weights_loaded); end
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL load7_ready: got %b want 0", ready_in); end
      weight_in = 16'h0100;
      tick();
      valid_weight_in = 1'b0;
      vectors++; if (weights_loaded !== 1'b1) begin miscompares++; $display("FAIL load8_loaded: got %b want 1", weights_loaded); end
      vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL load8_ready: got %b want 1", ready_in); end
      // A stray ninth word must leave the RAM untouched (checked by the next test).
      valid_weight_in = 1'b1;
      weight_in       = 16'h7F00;
      tick();
      valid_weight_in = 1'b0;
      vectors++; if (weights_loaded !== 1'b1) begin miscompares++; $display("FAIL load9_loaded: got %b want 1", weights_loaded); end
   endtask

   task automatic test_dot_product();
      int t;
      bit ok;
      clear_q();
      send_pixel(16'h0100, 16'h0200, 16'h0300, 16'h0400, t, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL dot_accept: got timeout want accept"); end
      wait_to(t + 11);
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL dot_ready_busy: got %b want 0", ready_in); end
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL dot_valid_t11: got %b want 1", valid_out); end
      tick();
      vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL dot_ready_back: got %b want 1", ready_in); end
      vectors++;
      if (q_val.size() != 2) begin
         miscompares++; $display("FAIL dot_count: got %0d want 2", q_val.size());
      end else begin
         vectors++; if (q_val[0] !== 16'h0A00) begin miscompares++; $display("FAIL dot_co0: got %h want 0a00", q_val[0]); end
         vectors++; if (q_val[1] !== 16'h0A00) begin miscompares++; $display("FAIL dot_co1: got %h want 0a00", q_val[1]); end
         vectors++; if (q_cyc[0] != t + 7) begin miscompares++; $display("FAIL dot_lat0: got %0d want %0d", q_cyc[0], t + 7); end
         vectors++; if (q_cyc[1] != t + 11) begin miscompares++; $display("FAIL dot_lat1: got %0d want %0d", q_cyc[1], t + 11); end
         vectors++; if (q_fd[1] !== 1'b0) begin miscompares++; $display("FAIL dot_fd: got %b want 0", q_fd[1]); end
      end
      vectors++; if (q_val_r.size() != 2) begin miscompares++; $display("FAIL dot_r_count: got %0d want 2", q_val_r.size()); end
   endtask

   task automatic test_saturation_relu();
      int t;
      bit ok;
      pulse_clear();
      load_w(16'h7F00, 16'h7F00);
      clear_q();
      send_pixel(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, t, ok);
      wait_q(2, 30);
      vectors++;
      if (q_val.size() != 2 || q_val_r.size() != 2) begin
         miscompares++; $display("FAIL sat_pos_count: got %0d/%0d want 2/2", q_val.size(), q_val_r.size());
      end else begin
         vectors++; if (q_val[0] !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos_co0: got %h want 7fff", q_val[0]); end
         vectors++; if (q_val[1] !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos_co1: got %h want 7fff", q_val[1]); end
         vectors++; if (q_val_r[0] !== 16'h7FFF) begin miscompares++; $display("FAIL sat_pos_relu: got %h want 7fff", q_val_r[0]); end
      end
      pulse_clear();
      load_w(16'h7F00, 16'h7F00);
      clear_q();
      send_pixel(16'h8100, 16'h8100, 16'h8100, 16'h8100, t, ok);
      wait_q(2, 30);
      vectors++;
      if (q_val.size() != 2 || q_val_r.size() != 2) begin
         miscompares++; $display("FAIL sat_neg_count: got %0d/%0d want 2/2", q_val.size(), q_val_r.size());
      end else begin
         vectors++; if (q_val[0] !== 16'h8000) begin miscompares++; $display("FAIL sat_neg_co0: got %h want 8000", q_val[0]); end
         vectors++; if (q_val[1] !== 16'h8000) begin miscompares++; $display("FAIL sat_neg_co1: got %h want 8000", q_val[1]); end
         vectors++; if (q_val_r[0] !== 16'h0000) begin miscompares++; $display("FAIL relu_neg_co0: got %h want 0000", q_val_r[0]); end
         vectors++; if (q_val_r[1] !== 16'h0000) begin miscompares++; $display("FAIL relu_neg_co1: got %h want 0000", q_val_r[1]); end
      end
   endtask

   task automatic test_stride2();
      int t;
      bit ok, all_ok;
      logic [DW-1:0] v;
      logic [DW-1:0] exp_q[$];
      pulse_clear();
      load_w(16'h0100, 16'h0200);
      clear_q();
      all_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         v = DW'((i + 1) * 256);
         // Channels all equal v: co0 = 4*v*1.0, co1 = 4*v*2.0.
         if (((i / 4) % 2 == 0) && ((i % 4) % 2 == 0)) begin
            exp_q.push_back(DW'(4 * (i + 1) * 256));
            exp_q.push_back(DW'(8 * (i + 1) * 256));
         end
         send_pixel(v, v, v, v, t, ok);
         all_ok = all_ok && ok;
      end
      vectors++; if (!all_ok) begin miscompares++; $display("FAIL stride_accept: got timeout want accept"); end
      wait_q(8, 60);
      repeat (20) tick();
      vectors++;
      if (q_val.size() != 8) begin
         miscompares++; $display("FAIL stride_count: got %0d want 8", q_val.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            vectors++;
            if (q_val[k] !== exp_q[k]) begin
               miscompares++; $display("FAIL stride_val[%0d]: got %h want %h", k, q_val[k], exp_q[k]);
            end
         end
         vectors++; if (q_fd[7] !== 1'b1) begin miscompares++; $display("FAIL stride_fd_last: got %b want 1", q_fd[7]); end
      end
      vectors++; if (fd_pulses != 1) begin miscompares++; $display("FAIL stride_fd_pulses: got %0d want 1", fd_pulses); end
   endtask

   task automatic test_abort();
      int t;
      bit ok;
      pulse_clear();
      load_w(16'h0100, 16'h0100);
      clear_q();
      send_pixel(16'h0100, 16'h0200, 16'h0300, 16'h0400, t, ok);
      wait_to(t + 3);
      weight_clear = 1'b1;
      tick();
      weight_clear = 1'b0;
      vectors++; if (weights_loaded !== 1'b0) begin miscompares++; $display("FAIL abort_loaded: got %b want 0", weights_loaded); end
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL abort_ready: got %b want 0", ready_in); end
      repeat (20) tick();
      vectors++; if (q_val.size() != 0) begin miscompares++; $display("FAIL abort_no_out: got %0d want 0", q_val.size()); end
      load_w(16'h0200, 16'h0200);
      vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL abort_reload_ready: got %b want 1", ready_in); end
      clear_q();
      send_pixel(16'h0100, 16'h0200, 16'h0300, 16'h0400, t, ok);
      wait_q(2, 30);
      vectors++;
      if (q_val.size() != 2) begin
         miscompares++; $display("FAIL abort_reload_count: got %0d want 2", q_val.size());
      end else begin
         vectors++; if (q_val[0] !== 16'h1400) begin miscompares++; $display("FAIL abort_reload_co0: got %h want 1400", q_val[0]); end
         vectors++; if (q_val[1] !== 16'h1400) begin miscompares++; $display("FAIL abort_reload_co1: got %h want 1400", q_val[1]); end
      end
   endtask

   task automatic test_reset_mid();
      int t;
      bit ok;
      pulse_clear();
      load_w(16'h0100, 16'h0100);
      clear_q();
      send_pixel(16'h0100, 16'h0200, 16'h0300, 16'h0400, t, ok);
      wait_to(t + 3);
      reset = 1'b0;
      #1;
      vectors++; if (pxl_out !== 16'h0000) begin miscompares++; $display("FAIL rst_mid_pxl: got %h want 0000", pxl_out); end
      vectors++; if (weights_loaded !== 1'b0) begin miscompares++; $display("FAIL rst_mid_loaded: got %b want 0", weights_loaded); end
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 0", ready_in); end
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", valid_out); end
      repeat (2) tick();
      reset = 1'b1;
      repeat (20) tick();
      vectors++; if (q_val.size() != 0) begin miscompares++; $display("FAIL rst_after_no_out: got %0d want 0", q_val.size()); end
      vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL rst_after_ready: got %b want 0", ready_in); end
      vectors++; if (pxl_out !== 16'h0000) begin miscompares++; $display("FAIL rst_after_pxl: got %h want 0000", pxl_out); end
      load_w(16'h0100, 16'h0100);
      vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL rst_reload_ready: got %b want 1", ready_in); end
      clear_q();
      send_pixel(16'h0100, 16'h0200, 16'h0300, 16'h0400, t, ok);
      wait_q(2, 30);
      vectors++;
      if (q_val.size() != 2) begin
         miscompares++; $display("FAIL rst_reload_count: got %0d want 2", q_val.size());
      end else begin
         vectors++; if (q_val[0] !== 16'h0A00) begin miscompares++; $display("FAIL rst_reload_co0: got %h want 0a00", q_val[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_weight_load();
      test_dot_product();
      test_saturation_relu();
      test_stride2();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
